fifo_wr_framer: RTL
===================

# fifo_wr_framer

Write-side packet framer sitting directly upstream of `async_fifo`, in the `wr_clk` domain. Accepts a byte stream with valid/ready/last handshaking and writes framed packets into the FIFO write port: one header byte carrying an 8-bit sequence number, the payload bytes, and an optional XOR checksum trailer. Honours FIFO `full` so no write is ever issued while `full` is high. Enforces a maximum payload length by truncation.

## Interface
- `DATA_W`, 8: byte width; matches FIFO `wr_data`.
- `MAX_LEN`, 16: maximum payload bytes per packet, ≥2.
- `wr_clk` in 1: write-domain clock, same clock as FIFO write side.
- `rst_n` in 1: reset, asynchronous, active-high.
- `src_valid` in 1: source byte valid.
- `src_data` in DATA_W: source byte.
- `src_last` in 1: marks the final byte of a packet.
- `src_ready` out 1: byte accepted when `src_valid && src_ready` at posedge.
- `full` in 1: FIFO full flag.
- `wr_en` out 1: FIFO write enable.
- `wr_data` out DATA_W: FIFO write data.
- `busy` out 1: high in any state other than IDLE.
- `trunc_err` out 1: one-cycle pulse when a packet is truncated.
- `pkt_count` out 16: number of packets fully framed; wraps at 65535→0.

## Operation
- States: IDLE, HDR, DATA, CSUM, DROP.
- IDLE: on `src_valid` → HDR. No byte consumed. `src_ready`=0.
- HDR: `wr_en = !full`, `wr_data = seq`. On write, csum ← seq, len ← 0, → DATA.
- DATA: `src_ready = !full`; `wr_en = src_valid && !full`; `wr_data = src_data`. On accept: csum ^= byte, len++.
  - `src_last` → CSUM (or IDLE without checksum feature).
  - len reaches MAX_LEN without `src_last` → `trunc_err` pulse, drop_pending ← 1, → CSUM (or DROP without feature).
- CSUM: `wr_en = !full`, `wr_data = csum`. On write → DROP if drop_pending, else IDLE.
- DROP: `src_ready`=1, `wr_en`=0; remaining bytes discarded; on accepted `src_last` → IDLE, drop_pending ← 0.
- Packet completion (entry into IDLE or DROP from the final written byte): seq++ (mod 256), pkt_count++. A truncated packet counts as framed.
- `wr_en`, `src_ready`, `wr_data` are combinational from state, `full`, `src_valid`; `wr_data` = 0 in IDLE/DROP.
- `full` high: no write, no accept, state held; resumes on the first cycle `full` is low.
- Reset mid-packet: all state returns to reset values immediately; the partial frame already in the FIFO is not recalled.

## Timing
- Reset values: state IDLE, seq 0, csum 0, len 0, drop_pending 0, `trunc_err` 0, `pkt_count` 0, hence `wr_en` 0, `src_ready` 0, `busy` 0, `wr_data` 0.
- First header write occurs one cycle after `src_valid` is first seen in IDLE.
- With `full` low and `src_valid` continuous: N-byte packet occupies N+3 cycles (IDLE, HDR, N×DATA, CSUM), i.e. N+2 FIFO writes.
- Back-to-back packets: one IDLE bubble between packets.
- `trunc_err` asserts in the cycle after the MAX_LEN-th byte is accepted and lasts one cycle.
- Arithmetic: len width `$clog2(MAX_LEN+1)`; seq 8 bits, wraps 255→0.

## Configuration
- `FIFO_FRAMER_CSUM_EN` defined: CSUM state present; trailer byte = XOR of header and all written payload bytes.
- Undefined: CSUM state and csum register removed. DATA goes directly to IDLE or DROP; each packet is N+1 FIFO writes.

## Structure
- Package `fifo_framer_pkg`: state enum typedef, `SEQ_W`=8, `PKT_CNT_W`=16.
- Sub-module `framer_csum`: XOR accumulator with load/accumulate/clear. Instantiated only under `FIFO_FRAMER_CSUM_EN`.

## Test plan
- Single packet 0x11,0x22,0x33 (last on 0x33), `full`=0, CSUM_EN: FIFO writes 0x00,0x11,0x22,0x33,0x00 (0x00^0x11^0x22^0x33); `pkt_count`=1.
- Two back-to-back packets: second header = 0x01; one IDLE cycle between packets; `pkt_count`=2.
- `full` forced high for 4 cycles mid-payload: `wr_en`=0 and `src_ready`=0 throughout; no byte lost or duplicated after release.
- 20-byte packet with MAX_LEN=16: 16 payload bytes written, `trunc_err` pulses once, bytes 17–20 dropped, checksum written; next packet header = 0x01.
- Reset asserted in DATA after 2 bytes: outputs at reset values immediately; after release, next header = 0x00.
- Build without `FIFO_FRAMER_CSUM_EN`: 3-byte packet yields exactly 4 writes (header + 3 bytes).

Source files
------------

// File: rtl/fifo_framer_pkg.sv
// Shared types and widths for the FIFO write-side framer.
// Optional checksum trailer is enabled by defining FIFO_FRAMER_CSUM_EN.
package fifo_framer_pkg;

  localparam int SEQ_W     = 8;
  localparam int PKT_CNT_W = 16;

`ifdef FIFO_FRAMER_CSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DROP
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DROP
  } state_t;
`endif

endpackage

// File: rtl/framer_csum.sv
// XOR accumulator for the framer trailer byte: clear has priority over load,
// load over accumulate. Used only when FIFO_FRAMER_CSUM_EN is defined.
module framer_csum
  import fifo_framer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              acc,
  input  logic [DATA_W-1:0] acc_val,
  output logic [DATA_W-1:0] csum
);

  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clear)     csum_d = '0;
    else if (load) csum_d = load_val;
    else if (acc)  csum_d = csum_q ^ acc_val;
  end

  // Reset is active-high, matching the rest of the write domain.
  always_ff @(posedge wr_clk or posedge rst_n) begin
    if (rst_n) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign csum = csum_q;

endmodule

// File: rtl/fifo_wr_framer.sv
// Write-side packet framer feeding async_fifo: header (sequence number),
// payload truncated at MAX_LEN, optional XOR trailer under FIFO_FRAMER_CSUM_EN.
module fifo_wr_framer
  import fifo_framer_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16
) (
  input  logic                 wr_clk,
  input  logic                 rst_n,
  input  logic                 src_valid,
  input  logic [DATA_W-1:0]    src_data,
  input  logic                 src_last,
  output logic                 src_ready,
  input  logic                 full,
  output logic                 wr_en,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 busy,
  output logic                 trunc_err,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t               state_q, state_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 drop_q, drop_d;
  logic                 trunc_q, trunc_d;
  logic [PKT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 accept;
  logic                 done;

`ifdef FIFO_FRAMER_CSUM_EN
  logic [DATA_W-1:0] csum;

  framer_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .wr_clk   (wr_clk),
    .rst_n    (rst_n),
    .clear    (state_q == ST_IDLE),
    .load     ((state_q == ST_HDR) && !full),
    .load_val (DATA_W'(seq_q)),
    .acc      ((state_q == ST_DATA) && accept),
    .acc_val  (src_data),
    .csum     (csum)
  );
`endif

  always_comb begin
    wr_en     = 1'b0;
    src_ready = 1'b0;
    wr_data   = '0;
    case (state_q)
      ST_HDR: begin
        wr_en   = !full;
        wr_data = DATA_W'(seq_q);
      end
      ST_DATA: begin
        src_ready = !full;
        wr_en     = src_valid && !full;
        wr_data   = src_data;
      end
`ifdef FIFO_FRAMER_CSUM_EN
      ST_CSUM: begin
        wr_en   = !full;
        wr_data = csum;
      end
`endif
      ST_DROP: src_ready = 1'b1;
      default: ;
    endcase
  end

  assign accept = src_valid && src_ready;

  // done marks the final FIFO write of a frame; truncated frames count too.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    len_d   = len_q;
    drop_d  = drop_q;
    trunc_d = 1'b0;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (src_valid) state_d = ST_HDR;
      ST_HDR: begin
        if (!full) begin
          len_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          len_d = len_q + 1'b1;
          if (src_last) begin
`ifdef FIFO_FRAMER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
            done    = 1'b1;
`endif
          end else if (len_q == LEN_W'(MAX_LEN - 1)) begin
            trunc_d = 1'b1;
            drop_d  = 1'b1;
`ifdef FIFO_FRAMER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DROP;
            done    = 1'b1;
`endif
          end
        end
      end
`ifdef FIFO_FRAMER_CSUM_EN
      ST_CSUM: begin
        if (!full) begin
          done    = 1'b1;
          state_d = drop_q ? ST_DROP : ST_IDLE;
        end
      end
`endif
      ST_DROP: begin
        if (accept && src_last) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (done) begin
      seq_d = seq_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wr_clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      len_q   <= '0;
      drop_q  <= 1'b0;
      trunc_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      len_q   <= len_d;
      drop_q  <= drop_d;
      trunc_q <= trunc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign trunc_err = trunc_q;
  assign pkt_count = cnt_q;

endmodule
